// File: rtl/lzc_pkg.sv
// Shared configuration for the leading-zero-count denormalizer:
// default data width, shift-count derivation and the stage record layout.
package lzc_pkg;

   localparam int LZC_WIDTH = 16;

   // Width of the shift-count index for a given data width.
   function automatic int lzc_count(input int width);
      return $clog2(width);
   endfunction

   localparam int LZC_COUNT = lzc_count(LZC_WIDTH);

   // One pipeline stage: valid bit, partially shifted data, sticky so far,
   // and the count bits still to be applied by later stages.
   typedef struct packed {
      logic                 valid;
      logic [LZC_WIDTH-1:0] data;
      logic                 sticky;
      logic [LZC_COUNT:0]   cnt;
   } stage_t;

endpackage

// File: rtl/lzc_denormalizer_rshift_stage.sv
// Conditional logical right shift by 2**K with sticky accumulation.
// Purely combinational; one instance per shift-count bit.
module rshift_stage
   import lzc_pkg::*;
#(
   parameter int WIDTH = LZC_WIDTH,
   parameter int K     = 0
) (
   input  logic             en,
   input  logic [WIDTH-1:0] src,
   input  logic             src_sticky,
   output logic [WIDTH-1:0] dst,
   output logic             dst_sticky
);

   localparam int SH = 1 << K;

   assign dst        = en ? (src >> SH) : src;
   // Bits falling off the bottom fold into the sticky flag.
   assign dst_sticky = src_sticky | (en & (|src[SH-1:0]));

endmodule

// File: rtl/lzc_denormalizer.sv
// Two-stage denormalizer: restores a leading-zero count as a logical right
// shift and reports a sticky bit for everything shifted out. S1 applies the
// upper count bits plus the zero/overflow decode, S2 the lower count bits.
// Valid/ready on both sides; a full pipeline stalls cleanly under backpressure.
module lzc_denormalizer
   import lzc_pkg::*;
#(
   parameter  int WIDTH = LZC_WIDTH,
   localparam int COUNT = lzc_count(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [COUNT:0]   in_count,
   input  logic             in_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sticky
);

   // Count bits [LO-1:0] are applied in S2, [COUNT-1:LO] in S1.
   localparam int           LO       = COUNT / 2;
   localparam logic [COUNT:0] RES_MASK = (COUNT+1)'((1 << LO) - 1);

   // Same layout as lzc_pkg::stage_t, sized by this instance's WIDTH.
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
      logic             sticky;
      logic [COUNT:0]   cnt;
   } stage_rec_t;

   stage_rec_t r1, r2;
   stage_rec_t s1_next, s2_next;
   logic       s2_adv;

   // ---------------- S1 shift chain ----------------
   logic [COUNT-LO:0][WIDTH-1:0] s1_d;
   logic [COUNT-LO:0]            s1_s;

   assign s1_d[0] = in_data;
   assign s1_s[0] = 1'b0;

   for (genvar i = 0; i < COUNT-LO; i++) begin : g_s1
      rshift_stage #(.WIDTH(WIDTH), .K(LO+i)) u_sh (
         .en         (in_count[LO+i]),
         .src        (s1_d[i]),
         .src_sticky (s1_s[i]),
         .dst        (s1_d[i+1]),
         .dst_sticky (s1_s[i+1])
      );
   end

   // S1 record: zero flag wins, then overflow, else the partial shift.
   always_comb begin
      s1_next       = '0;
      s1_next.valid = in_valid;
      if (in_zero) begin
         s1_next.data   = '0;
         s1_next.sticky = 1'b0;
      end else if (in_count[COUNT]) begin
         s1_next.data   = '0;
         s1_next.sticky = |in_data;
      end else begin
         s1_next.data   = s1_d[COUNT-LO];
         s1_next.sticky = s1_s[COUNT-LO];
         s1_next.cnt    = in_count & RES_MASK;
      end
   end

   // ---------------- S2 shift chain ----------------
   logic [LO:0][WIDTH-1:0] s2_d;
   logic [LO:0]            s2_s;

   assign s2_d[0] = r1.data;
   assign s2_s[0] = r1.sticky;

   for (genvar i = 0; i < LO; i++) begin : g_s2
      rshift_stage #(.WIDTH(WIDTH), .K(i)) u_sh (
         .en         (r1.cnt[i]),
         .src        (s2_d[i]),
         .src_sticky (s2_s[i]),
         .dst        (s2_d[i+1]),
         .dst_sticky (s2_s[i+1])
      );
   end

   // S2 record: residual count fully consumed here.
   always_comb begin
      s2_next        = '0;
      s2_next.valid  = r1.valid;
      s2_next.data   = s2_d[LO];
      s2_next.sticky = s2_s[LO];
   end

   // Residual-count bits that no later stage consumes.
   logic unused_cnt;
   assign unused_cnt = ^{r2.cnt, r1.cnt};

   // ---------------- Flow control ----------------
   assign s2_adv   = !r2.valid || out_ready;
   assign in_ready = !r1.valid || s2_adv;

   assign out_valid  = r2.valid;
   assign out_data   = r2.data;
   assign out_sticky = r2.sticky;

   // Stage registers: S2 loads from S1 when it advances; S1 loads a new beat
   // or empties when it hands off without a replacement.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1 <= '0;
         r2 <= '0;
      end else begin
         if (s2_adv)
            r2 <= s2_next;
         if (in_ready) begin
            if (in_valid)
               r1 <= s1_next;
            else
               r1.valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lzc_denormalizer.sv
// Bench for lzc_denormalizer (WIDTH=16): vector table, latency, backpressure,
// mid-operation reset and random soak, all checked through a scoreboard.
module tb_lzc_denormalizer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [4:0]  in_count = '0;
   logic        in_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_sticky;

   typedef struct packed {
      logic [15:0] d;
      logic        s;
   } exp_t;

   typedef struct {
      logic [15:0] d;
      logic [4:0]  c;
      logic        z;
      logic [15:0] ed;
      logic        es;
   } vec_t;

   exp_t sb[$];
   exp_t cur_exp = '0;
   int   checks = 0;
   int   errors = 0;
   bit   soak_done = 1'b0;

   always #5 clk = ~clk;

   lzc_denormalizer #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_count   (in_count),
      .in_zero    (in_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sticky (out_sticky)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Independent shift/sticky reference.
   function automatic exp_t ref_model(input logic [15:0] d, input logic [4:0] c, input logic z);
      exp_t        r;
      logic [15:0] m;
      r = '0;
      if (z) begin
         r = '0;
      end else if (c >= 5'd16) begin
         r.d = '0;
         r.s = |d;
      end else begin
         m   = 16'((32'h1 << c) - 32'h1);
         r.d = d >> c;
         r.s = |(d & m);
      end
      return r;
   endfunction

   // Scoreboard: push on input handshake, pop and compare on output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && in_valid && in_ready)
         sb.push_back(cur_exp);
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h/%b want no beat", out_data, out_sticky);
         end else begin
            e = sb.pop_front();
            chk("beat_data", 32'(out_data), 32'(e.d));
            chk("beat_sticky", 32'(out_sticky), 32'(e.s));
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic [4:0] c, input logic z, input exp_t e);
      bit acc = 1'b0;
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_count = c;
      in_zero  = z;
      cur_exp  = e;
      while (!acc && n < 500) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept want accept within 500 cycles");
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got no finish want finish before 900us");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [11];
      tbl[0]  = '{16'h8000, 5'd3,  1'b0, 16'h1000, 1'b0};
      tbl[1]  = '{16'h8001, 5'd1,  1'b0, 16'h4000, 1'b1};
      tbl[2]  = '{16'hA000, 5'd16, 1'b0, 16'h0000, 1'b1};
      tbl[3]  = '{16'hFFFF, 5'd5,  1'b1, 16'h0000, 1'b0};
      tbl[4]  = '{16'h8000, 5'd0,  1'b0, 16'h8000, 1'b0};
      tbl[5]  = '{16'hC003, 5'd2,  1'b0, 16'h3000, 1'b1};
      tbl[6]  = '{16'h8000, 5'd15, 1'b0, 16'h0001, 1'b0};
      tbl[7]  = '{16'h8000, 5'd31, 1'b0, 16'h0000, 1'b1};
      tbl[8]  = '{16'hF0F0, 5'd8,  1'b0, 16'h00F0, 1'b1};
      tbl[9]  = '{16'h8010, 5'd4,  1'b0, 16'h0801, 1'b0};
      tbl[10] = '{16'h0000, 5'd16, 1'b0, 16'h0000, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_out_sticky", 32'(out_sticky), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // Latency: accepted beat appears exactly two cycles later
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h8000;
      in_count  = 5'd3;
      in_zero   = 1'b0;
      cur_exp   = '{d: 16'h1000, s: 1'b0};
      @(negedge clk);
      chk("lat_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
      chk("lat_cycle2_out_data", 32'(out_data), 32'h1000);
      @(posedge clk);
      #1;

      // Vector table, back to back
      for (int i = 0; i < 11; i++)
         send(tbl[i].d, tbl[i].c, tbl[i].z, {tbl[i].ed, tbl[i].es});
      drain();

      // Backpressure: two beats fill the pipe, third waits
      out_ready = 1'b0;
      send(16'hFFFF, 5'd0, 1'b0, {16'hFFFF, 1'b0});
      send(16'hFFFF, 5'd4, 1'b0, {16'h0FFF, 1'b1});
      fork
         send(16'hFFFF, 5'd15, 1'b0, {16'h0001, 1'b1});
         begin
            repeat (2) begin
               @(negedge clk);
               chk("bp_in_ready", 32'(in_ready), 32'd0);
               chk("bp_out_valid", 32'(out_valid), 32'd1);
               chk("bp_hold_data", 32'(out_data), 32'hFFFF);
               chk("bp_hold_sticky", 32'(out_sticky), 32'd0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages full: in-flight beats vanish
      out_ready = 1'b0;
      send(16'h8000, 5'd1, 1'b0, {16'h4000, 1'b0});
      send(16'h8000, 5'd2, 1'b0, {16'h2000, 1'b0});
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", 32'(out_data), 32'd0);
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      send(16'h9000, 5'd3, 1'b0, {16'h1200, 1'b0});
      drain();

      // Random soak with random backpressure
      fork
         begin
            logic [15:0] d;
            logic [4:0]  c;
            logic        z;
            for (int i = 0; i < 10000; i++) begin
               d = 16'($urandom);
               c = 5'($urandom_range(0, 20));
               z = ($urandom_range(0, 15) == 0);
               send(d, c, z, ref_model(d, c, z));
            end
            soak_done = 1'b1;
         end
         begin
            while (!soak_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lzc_denormalizer.md
LZC_DENORMALIZER -- requirements
Module: lzc_denormalizer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data word width; it shall be a power of two and at least 2.
REQ-002 SHALL have localparam COUNT, equal to $clog2(WIDTH), giving the shift-count index width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts the input beat this cycle.
REQ-007 in_data  input  WIDTH  normalized word (leading one at MSB).
REQ-008 in_count  input  COUNT+1  leading-zero count to restore, as a right shift.
REQ-009 in_zero  input  1  original value was all-zero.
REQ-010 out_valid  output  1  output beat present.
REQ-011 out_ready  input  1  downstream accepts the output beat.
REQ-012 out_data  output  WIDTH  denormalized word.
REQ-013 out_sticky  output  1  OR of all nonzero bits shifted out.

Function
REQ-014 SHALL transfer an input beat on the cycle where in_valid and in_ready are both 1, and an output beat on the cycle where out_valid and out_ready are both 1.
REQ-015 SHALL compute out_data = in_data >> in_count (logical) and out_sticky = OR of in_data[in_count-1:0], with out_sticky = 0 when in_count = 0.
REQ-016 SHALL, when in_count >= WIDTH, force out_data = 0 and out_sticky = |in_data.
REQ-017 SHALL, when in_zero = 1, force out_data = 0 and out_sticky = 0, regardless of in_count.
REQ-018 SHALL be a 2-stage pipeline:
  - S1 applies the shift bits in_count[COUNT:COUNT/2] plus the overflow/zero decode.
  - S2 applies in_count[COUNT/2-1:0].
  - Each stage register holds a valid bit, the data, the sticky bit and the residual count.
REQ-019 SHALL present a beat on out_valid exactly 2 cycles after acceptance when out_ready is held high (latency 2, throughput 1 per cycle).
REQ-020 SHALL advance S2 when S2 is empty or out_ready = 1.
REQ-021 SHALL advance S1 into S2 whenever S2 advances.
REQ-022 SHALL drive in_ready = !S1.valid || S2 advances; the path from out_ready to in_ready is combinational.
REQ-023 SHALL hold out_data and out_sticky stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL preserve beat order with no loss or duplication under any backpressure pattern.
REQ-025 SHALL, on simultaneous accept and emit with both stages full, shift every stage by one slot in the same cycle.
REQ-026 SHALL keep in_ready independent of in_valid.
REQ-027 SHALL never assert out_valid for an input presented while in_ready = 0.

Reset
REQ-028 SHALL, while rst = 1 on a clock edge, clear both stage valid bits, data, sticky and residual count to 0.
REQ-029 SHALL drive out_valid = 0, out_data = 0 and out_sticky = 0 in the cycle after reset, and in_ready = 1.
REQ-030 SHALL discard in-flight beats when reset is asserted mid-operation, and emit no output for them after reset deasserts.

Structure
REQ-031 SHALL import a shared package lzc_pkg holding the default WIDTH and the COUNT derivation.
REQ-032 The same package SHALL hold the stage-record typedef {valid, data, sticky, residual count}.
REQ-033 SHALL instantiate sub-module rshift_stage: a combinational conditional right shift by 2**k with sticky accumulation, parameterized by WIDTH and k, used once per count bit.
REQ-034 Pipeline registers SHALL live only in lzc_denormalizer.

Verification (WIDTH=16)
REQ-035 in_data=16'h8000, in_count=3, out_ready=1 -> out_data=16'h1000, out_sticky=0, out_valid exactly 2 cycles after accept.
REQ-036 in_data=16'h8001, in_count=1 -> out_data=16'h4000, out_sticky=1.
REQ-037 Zero and overflow cases:
  - in_count=16, in_data=16'hA000 -> out_data=0, out_sticky=1.
  - in_zero=1, in_data=16'hFFFF, in_count=5 -> out_data=0, out_sticky=0.
REQ-038 Backpressure:
  - Stimulus: 3 back-to-back beats (counts 0, 4, 15 on in_data=16'hFFFF) with out_ready=0 for 4 cycles.
  - Required: in_ready drops after 2 beats are held; outputs are 16'hFFFF/0, 16'h0FFF/1, 16'h0001/1 in order, stable while stalled.
REQ-039 Reset mid-operation:
  - Stimulus: rst for 1 cycle with both stages full.
  - Required: next cycle out_valid=0, in_ready=1; no stale beat ever emitted.
REQ-040 Random soak: 10k random beats with random out_ready, checked against the shift/sticky reference model of REQ-015..REQ-017.
